button_event_decoder: RTL and testbench

Consumes the debounced button levels produced by the per-button debouncers and turns them into one-cycle action events for the game logic: press, release, long-hold level and auto-repeat pulses. It sits between the input debouncing stage and the player-control FSMs, so game logic never does its own edge detection. It is one per-button FSM plus counter, replicated `NUM_BUTTONS` times, with registered outputs.

---
 rtl/button_event_decoder.sv | 137 +++++++++++++
 tb/tb_button_event_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns debounced button levels into one-cycle press, release and repeat events plus a hold level.
// Each channel runs its own IDLE/PRESSED/HELD FSM and counter; all outputs are registered.
module button_event_decoder #(
    parameter int NUM_BUTTONS   = 4,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10,
    parameter int CNT_W         = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] buttons_debounced,
    input  logic                   enable,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] hold_level,
    output logic [NUM_BUTTONS-1:0] repeat_pulse,
    output logic                   any_pressed
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

    state_t                   state_q [NUM_BUTTONS];
    state_t                   state_d [NUM_BUTTONS];
    logic [CNT_W-1:0]         cnt_q   [NUM_BUTTONS];
    logic [CNT_W-1:0]         cnt_d   [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0]   prev_q, prev_d;
    logic [NUM_BUTTONS-1:0]   press_q, press_d;
    logic [NUM_BUTTONS-1:0]   release_q, release_d;
    logic [NUM_BUTTONS-1:0]   hold_q, hold_d;
    logic [NUM_BUTTONS-1:0]   repeat_q, repeat_d;
    logic                     any_q, any_d;

    // Per-channel next state, counter and event decode; prev tracks the input even when disabled.
    always_comb begin
        prev_d    = buttons_debounced;
        press_d   = {NUM_BUTTONS{1'b0}};
        release_d = {NUM_BUTTONS{1'b0}};
        hold_d    = {NUM_BUTTONS{1'b0}};
        repeat_d  = {NUM_BUTTONS{1'b0}};
        any_d     = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!enable) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = CNT_ZERO;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (buttons_debounced[i] && !prev_q[i]) begin
                            press_d[i] = 1'b1;
                            cnt_d[i]   = CNT_ZERO;
                            state_d[i] = ST_PRESSED;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        // A release on the threshold edge wins over entering HELD.
                        if (!buttons_debounced[i]) begin
                            release_d[i] = 1'b1;
                            state_d[i]   = ST_IDLE;
                        end else if (cnt_q[i] == HOLD_LAST) begin
                            state_d[i]  = ST_HELD;
                            hold_d[i]   = 1'b1;
                            repeat_d[i] = 1'b1;
                            cnt_d[i]    = CNT_ZERO;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!buttons_debounced[i]) begin
                            release_d[i] = 1'b1;
                            state_d[i]   = ST_IDLE;
                        end else if (cnt_q[i] == REPEAT_LAST) begin
                            hold_d[i]   = 1'b1;
                            repeat_d[i] = 1'b1;
                            cnt_d[i]    = CNT_ZERO;
                        end else begin
                            hold_d[i] = 1'b1;
                            cnt_d[i]  = cnt_q[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end
                endcase
            end
            any_d = any_d | (state_d[i] != ST_IDLE);
        end
    end

    // State, counters and registered outputs; prev resets high so a held button needs a fresh press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= {NUM_BUTTONS{1'b1}};
            press_q   <= {NUM_BUTTONS{1'b0}};
            release_q <= {NUM_BUTTONS{1'b0}};
            hold_q    <= {NUM_BUTTONS{1'b0}};
            repeat_q  <= {NUM_BUTTONS{1'b0}};
            any_q     <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            prev_q    <= prev_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            repeat_q  <= repeat_d;
            any_q     <= any_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign hold_level    = hold_q;
    assign repeat_pulse  = repeat_q;
    assign any_pressed   = any_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed table-driven bench for button_event_decoder (HOLD_CYCLES=5, REPEAT_CYCLES=3),
// plus hand-written reset sequences.
module tb_button_event_decoder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] buttons;
    logic [3:0] press_pulse, release_pulse, hold_level, repeat_pulse;
    logic       any_pressed;

    button_event_decoder #(
        .NUM_BUTTONS  (4),
        .HOLD_CYCLES  (5),
        .REPEAT_CYCLES(3),
        .CNT_W        (16)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .buttons_debounced(buttons),
        .enable           (enable),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .hold_level       (hold_level),
        .repeat_pulse     (repeat_pulse),
        .any_pressed      (any_pressed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] btn;
        logic       en;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] hld;
        logic [3:0] rpt;
        logic       any;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic [3:0] b, input logic en, input logic [3:0] p,
                                input logic [3:0] r, input logic [3:0] h, input logic [3:0] rp,
                                input logic a);
        vec_t v;
        v.btn = b; v.en = en; v.prs = p; v.rel = r; v.hld = h; v.rpt = rp; v.any = a;
        vecs.push_back(v);
    endfunction

    function automatic logic [16:0] obs();
        return {press_pulse, release_pulse, hold_level, repeat_pulse, any_pressed};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual(prs,rel,hld,rpt,any)=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
                     name, act[16:13], act[12:9], act[8:5], act[4:1], act[0],
                     req[16:13], req[12:9], req[8:5], req[4:1], req[0]);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the rising edge.
    task automatic drive(input logic [3:0] b, input logic en);
        @(negedge clock);
        buttons = b;
        enable  = en;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        buttons = 4'b0000;
        #12;
        check("reset_state", obs(), 17'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic press/release on ch0
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Hold ch2 for 20 edges: held from edge 5, repeats at 5, 8, 11, 14, 17
        add(4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        for (int e = 1; e < 20; e++) begin
            add(4'b0100, 1'b1, 4'b0000, 4'b0000,
                (e >= 5) ? 4'b0100 : 4'b0000,
                (e == 5 || e == 8 || e == 11 || e == 14 || e == 17) ? 4'b0100 : 4'b0000,
                1'b1);
        end
        add(4'b0000, 1'b1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Threshold race on ch1: release sampled on the edge that would enter HELD
        add(4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Simultaneous ch0+ch3 press, ch3 released first
        add(4'b1001, 1'b1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b1001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0001, 1'b1, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 1'b1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Enable gating: press while disabled is ignored until a fresh press
        add(4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b1);
        add(4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].btn, vecs[i].en);
            check($sformatf("vec%0d", i), obs(),
                  {vecs[i].prs, vecs[i].rel, vecs[i].hld, vecs[i].rpt, vecs[i].any});
        end

        // Button held through reset release: no press until released and pressed again
        @(negedge clock);
        reset_n = 1'b0;
        buttons = 4'b0001;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 1'b1);
            check($sformatf("held_thru_reset%0d", k), obs(), 17'd0);
        end
        drive(4'b0000, 1'b1);
        check("held_thru_reset_rel", obs(), 17'd0);
        drive(4'b0001, 1'b1);
        check("fresh_press", obs(), {4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1});
        for (int k = 1; k < 5; k++) begin
            drive(4'b0001, 1'b1);
            check($sformatf("pre_hold%0d", k), obs(), {16'd0, 1'b1});
        end
        drive(4'b0001, 1'b1);
        check("held_entry", obs(), {4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1});

        // Asynchronous reset mid-HELD clears outputs before the next edge, including the repeat pulse
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", obs(), 17'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(4'b0000, 1'b1);
        check("after_async_reset", obs(), 17'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
